queue_ctrl: RTL and testbench

QUEUE_CTRL -- requirements
Module: queue_ctrl

---
 rtl/queue_pkg.sv | 19 +
 rtl/queue_mem.sv | 35 +++
 rtl/queue_ctrl.sv | 99 +++++++++
 tb/tb_queue_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared types and defaults for the queue controller and its storage.
// Holds the occupancy state encoding and the default word/pointer widths.
package queue_pkg;

  localparam int DEFAULT_DATAWIDTH = 8;
  localparam int DEFAULT_ADDRWIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  // A single-entry queue (ADDRWIDTH == 0) still needs a one-bit pointer vector.
  function automatic int ptr_width(input int addr_width);
    return (addr_width > 0) ? addr_width : 1;
  endfunction

endpackage

// File: rtl/queue_mem.sv
// DEPTH x DATAWIDTH register file: one write port, one asynchronous read port,
// all words cleared by reset.
module queue_mem
  import queue_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int ADDRWIDTH = DEFAULT_ADDRWIDTH
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                wr_en,
  input  logic [ptr_width(ADDRWIDTH)-1:0]     wr_addr,
  input  logic [DATAWIDTH-1:0]                wr_data,
  input  logic [ptr_width(ADDRWIDTH)-1:0]     rd_addr,
  output logic [DATAWIDTH-1:0]                rd_data
);

  localparam int DEPTH = 2 ** ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Show-ahead read: the head word is visible without a read strobe.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/queue_ctrl.sv
// Valid/ready FIFO controller: pointers, occupancy count and an EMPTY/PARTIAL/FULL
// FSM, plus step/direction strobes for a downstream occupancy counter.
module queue_ctrl
  import queue_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int ADDRWIDTH = DEFAULT_ADDRWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 PushValid,
  input  logic [DATAWIDTH-1:0] PushData,
  output logic                 PushReady,
  output logic                 PopValid,
  output logic [DATAWIDTH-1:0] PopData,
  input  logic                 PopReady,
  output logic [ADDRWIDTH:0]   Count,
  output logic                 Full,
  output logic                 Empty,
  output logic                 CntEn,
  output logic                 CntDir
);

  localparam int DEPTH = 2 ** ADDRWIDTH;
  localparam int PTRW  = ptr_width(ADDRWIDTH);
  localparam int CW    = ADDRWIDTH + 1;

  state_t          state_reg, state_next;
  logic [PTRW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push, pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Handshakes decode the state register directly so ready/valid never loop back.
  assign push = PushValid && (state_reg != FULL) && !Rst;
  assign pop  = PopReady && (state_reg != EMPTY) && !Rst;

  queue_mem #(
    .DATAWIDTH(DATAWIDTH),
    .ADDRWIDTH(ADDRWIDTH)
  ) u_mem (
    .Clk     (Clk),
    .Rst     (Rst),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (PushData),
    .rd_addr (rd_ptr_reg),
    .rd_data (PopData)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (push) state_next = (DEPTH == 1) ? FULL : PARTIAL;
      end
      PARTIAL: begin
        if (push && !pop && count_reg == CW'(DEPTH - 1))  state_next = FULL;
        else if (pop && !push && count_reg == CW'(1))     state_next = EMPTY;
      end
      FULL: begin
        if (pop) state_next = (DEPTH == 1) ? EMPTY : PARTIAL;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    Empty     = (state_reg == EMPTY);
    Full      = (state_reg == FULL);
    PushReady = (state_reg != FULL);
    PopValid  = (state_reg != EMPTY);
    CntEn     = push ^ pop;
    CntDir    = push;
    Count     = count_reg;
  end

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed self-checking bench for queue_ctrl with default parameters.
// A small reference queue tracks contents; key points also use hand constants.
module tb_queue_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          PushValid;
  logic [DW-1:0] PushData;
  logic          PushReady;
  logic          PopValid;
  logic [DW-1:0] PopData;
  logic          PopReady;
  logic [AW:0]   Count;
  logic          Full;
  logic          Empty;
  logic          CntEn;
  logic          CntDir;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model_q[$];

  queue_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .PushValid (PushValid),
    .PushData  (PushData),
    .PushReady (PushReady),
    .PopValid  (PopValid),
    .PopData   (PopData),
    .PopReady  (PopReady),
    .Count     (Count),
    .Full      (Full),
    .Empty     (Empty),
    .CntEn     (CntEn),
    .CntDir    (CntDir)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction: drive at the falling edge, check strobes before the rising
  // edge, update the reference queue at the edge, check state after it.
  task automatic txn(input logic pv, input logic [DW-1:0] pd, input logic pr);
    logic exp_push, exp_pop;
    int   occ;
    occ       = model_q.size();
    PushValid = pv;
    PushData  = pd;
    PopReady  = pr;
    #1;
    exp_push = pv && (occ < DEPTH);
    exp_pop  = pr && (occ > 0);
    check("push_ready", {31'd0, PushReady}, {31'd0, occ < DEPTH});
    check("pop_valid", {31'd0, PopValid}, {31'd0, occ > 0});
    check("cnt_en", {31'd0, CntEn}, {31'd0, exp_push ^ exp_pop});
    if (exp_push ^ exp_pop) check("cnt_dir", {31'd0, CntDir}, {31'd0, exp_push});
    if (occ > 0) check("pop_data", {24'd0, PopData}, {24'd0, model_q[0]});
    @(posedge Clk);
    if (exp_pop)  model_q.delete(0);
    if (exp_push) model_q.push_back(pd);
    @(negedge Clk);
    check("count", {27'd0, Count}, model_q.size());
    check("empty", {31'd0, Empty}, {31'd0, model_q.size() == 0});
    check("full", {31'd0, Full}, {31'd0, model_q.size() == DEPTH});
    $display("txn pv=%0b pd=%02h pr=%0b push=%0b pop=%0b count=%0d",
             pv, pd, pr, exp_push, exp_pop, Count);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [AW:0]   step_counts [6];
    logic [DW-1:0] step_data [3];
    step_counts = '{5'd1, 5'd2, 5'd3, 5'd2, 5'd1, 5'd0};
    step_data   = '{8'h11, 8'h22, 8'h33};

    Rst = 1'b1; PushValid = 1'b0; PushData = '0; PopReady = 1'b0;
    @(negedge Clk);
    check("rst_empty", {31'd0, Empty}, 32'd1);
    check("rst_cnt_en", {31'd0, CntEn}, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) txn(1'b0, 8'h00, 1'b0);
    check("idle_empty", {31'd0, Empty}, 32'd1);
    check("idle_full", {31'd0, Full}, 32'd0);
    check("idle_count", {27'd0, Count}, 32'd0);
    check("idle_push_ready", {31'd0, PushReady}, 32'd1);
    check("idle_pop_valid", {31'd0, PopValid}, 32'd0);
    check("idle_pop_data", {24'd0, PopData}, 32'd0);

    // Pop request while empty is ignored
    txn(1'b0, 8'h00, 1'b1);
    check("empty_pop_count", {27'd0, Count}, 32'd0);

    // Three pushes then three pops
    for (int i = 0; i < 3; i++) begin
      txn(1'b1, step_data[i], 1'b0);
      check("step_count", {27'd0, Count}, {27'd0, step_counts[i]});
      check("step_head", {24'd0, PopData}, 32'h11);
    end
    for (int i = 0; i < 3; i++) begin
      check("pop_order", {24'd0, PopData}, {24'd0, step_data[i]});
      txn(1'b0, 8'h00, 1'b1);
      check("step_count", {27'd0, Count}, {27'd0, step_counts[i+3]});
    end

    // Fill to DEPTH, then an extra push is dropped
    for (int i = 0; i < DEPTH; i++) begin
      w = 8'h40 + 8'(i);
      txn(1'b1, w, 1'b0);
    end
    check("fill_full", {31'd0, Full}, 32'd1);
    check("fill_push_ready", {31'd0, PushReady}, 32'd0);
    check("fill_count", {27'd0, Count}, 32'd16);
    txn(1'b1, 8'h99, 1'b0);
    check("overflow_count", {27'd0, Count}, 32'd16);
    check("overflow_head", {24'd0, PopData}, 32'h40);

    // Full with push and pop together: pop only
    txn(1'b1, 8'hEE, 1'b1);
    check("full_pp_count", {27'd0, Count}, 32'd15);
    check("full_pp_full", {31'd0, Full}, 32'd0);
    check("full_pp_head", {24'd0, PopData}, 32'h41);
    for (int i = 1; i < DEPTH; i++) begin
      w = 8'h40 + 8'(i);
      check("drain_order", {24'd0, PopData}, {24'd0, w});
      txn(1'b0, 8'h00, 1'b1);
    end
    check("drain_empty", {31'd0, Empty}, 32'd1);

    // Move pointers to 9, then load 5 words so the write pointer sits at 14
    for (int i = 0; i < 6; i++) txn(1'b1, 8'h30, 1'b0);
    for (int i = 0; i < 6; i++) txn(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      w = 8'h50 + 8'(i);
      txn(1'b1, w, 1'b0);
    end
    check("wrap_pre_count", {27'd0, Count}, 32'd5);
    for (int i = 0; i < 10; i++) begin
      w = 8'h60 + 8'(i);
      txn(1'b1, w, 1'b1);
      check("wrap_count", {27'd0, Count}, 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      w = 8'h65 + 8'(i);
      check("wrap_order", {24'd0, PopData}, {24'd0, w});
      txn(1'b0, 8'h00, 1'b1);
    end

    // Reset mid-operation with 7 words queued
    for (int i = 0; i < 7; i++) begin
      w = 8'h70 + 8'(i);
      txn(1'b1, w, 1'b0);
    end
    check("pre_rst_count", {27'd0, Count}, 32'd7);
    Rst = 1'b1; PushValid = 1'b1; PushData = 8'h77; PopReady = 1'b1;
    #1;
    check("mid_rst_count", {27'd0, Count}, 32'd0);
    check("mid_rst_empty", {31'd0, Empty}, 32'd1);
    check("mid_rst_full", {31'd0, Full}, 32'd0);
    check("mid_rst_push_ready", {31'd0, PushReady}, 32'd1);
    check("mid_rst_pop_valid", {31'd0, PopValid}, 32'd0);
    check("mid_rst_cnt_en", {31'd0, CntEn}, 32'd0);
    check("mid_rst_pop_data", {24'd0, PopData}, 32'd0);
    model_q.delete();
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0; PushValid = 1'b0; PopReady = 1'b0;
    #1;
    check("post_rst_count", {27'd0, Count}, 32'd0);
    @(negedge Clk);
    txn(1'b1, 8'hAA, 1'b0);
    check("post_rst_head", {24'd0, PopData}, 32'hAA);
    check("post_rst_pop_valid", {31'd0, PopValid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
